// File: rtl/jtopl_pkg.sv
// Shared constants for the OPL phase generator: MUL table, vibrato shape, widths.
package jtopl_pkg;

  localparam int PHINC_W = 17;  // phase increment width before MUL
  localparam int OPW     = 10;  // operator phase width seen downstream

  // MUL factor stored doubled so code 0 (x0.5) stays an integer; product >> 1.
  localparam logic [15:0][4:0] MUL_X2 = {
    5'd30, 5'd30, 5'd24, 5'd24, 5'd20, 5'd20, 5'd18, 5'd16,
    5'd14, 5'd12, 5'd10, 5'd8,  5'd6,  5'd4,  5'd2,  5'd1
  };

  // Vibrato shape per LFO position, bits {negative, full m, half m}.
  localparam logic [7:0][2:0] VIB_SHAPE = {
    3'b101, 3'b110, 3'b101, 3'b000, 3'b001, 3'b010, 3'b001, 3'b000
  };

endpackage

// File: rtl/jtopl_pg_mslot_if.sv
// Slot input bus and phase output bus of the multi-slot phase generator.
interface jtopl_pg_mslot_if #(parameter int SW = 5);
  logic          cen;
  logic          zero;
  logic [2:0]    block;
  logic [9:0]    fnum;
  logic [3:0]    mul;
  logic          nts;
  logic          vib_en;
  logic          vib_dep;
  logic [2:0]    vib_pos;
  logic          pg_rst;
  logic [3:0]    keycode;
  logic [9:0]    phase_op;
  logic [SW-1:0] slot_out;

  modport master (
    output cen, zero, block, fnum, mul, nts, vib_en, vib_dep, vib_pos, pg_rst,
    input  keycode, phase_op, slot_out
  );
  modport slave (
    input  cen, zero, block, fnum, mul, nts, vib_en, vib_dep, vib_pos, pg_rst,
    output keycode, phase_op, slot_out
  );
endinterface

// File: rtl/jtopl_pg_mslot_inc.sv
// Stage-1 combinational math: vibrato offset, fmod, octave shift and keycode.
module jtopl_pg_mslot_inc
  import jtopl_pkg::*;
(
  input  logic [2:0]         i_block,
  input  logic [9:0]         i_fnum,
  input  logic               i_nts,
  input  logic               i_vib_en,
  input  logic               i_vib_dep,
  input  logic [2:0]         i_vib_pos,
  output logic [PHINC_W-1:0] o_phinc,
  output logic [3:0]         o_keycode
);
  logic [2:0]  w_m;
  logic [2:0]  w_shape;
  logic [2:0]  w_mag;
  logic [10:0] w_fmod;

  // Vibrato depth from the top fnum bits, halved for shallow vibrato.
  assign w_m     = i_vib_dep ? i_fnum[9:7] : {1'b0, i_fnum[9:8]};
  assign w_shape = VIB_SHAPE[i_vib_pos];
  assign w_mag   = !i_vib_en  ? 3'd0 :
                   w_shape[1] ? w_m  :
                   w_shape[0] ? {1'b0, w_m[2:1]} : 3'd0;

  // Negative offsets never exceed fnum[9:7], so the subtraction cannot underflow.
  assign w_fmod  = w_shape[2] ? ({1'b0, i_fnum} - {8'd0, w_mag})
                              : ({1'b0, i_fnum} + {8'd0, w_mag});

  assign o_phinc   = PHINC_W'(({7'd0, w_fmod} << i_block) >> 1);
  assign o_keycode = {i_block, i_nts ? i_fnum[8] : i_fnum[9]};
endmodule

// File: rtl/jtopl_pg_mslot.sv
// Time-multiplexed three-stage phase generator with per-slot phase memory.
module jtopl_pg_mslot
  import jtopl_pkg::*;
#(
  parameter int SLOTS = 18,
  parameter int PW    = 20,
  parameter int SW    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  jtopl_pg_mslot_if.slave    bus
);
  logic [SW-1:0]      r_cnt;
  logic [SW-1:0]      w_slot;
  logic [PHINC_W-1:0] w_phinc;
  logic [3:0]         w_keycode;

  logic [PHINC_W-1:0] r1_phinc;
  logic [3:0]         r1_mul;
  logic               r1_rst;
  logic [SW-1:0]      r1_slot;
  logic [3:0]         r_keycode;

  logic [21:0]        w_prod2;
  logic [PW-1:0]      w_inc;
  logic [PW-1:0]      r2_inc;
  logic               r2_rst;
  logic [SW-1:0]      r2_slot;

  logic [PW-1:0]      r_mem [SLOTS];
  logic [PW-1:0]      w_acc;
  logic [OPW-1:0]     r_phase_op;
  logic [SW-1:0]      r_slot_out;

  // zero forces this input to slot 0; the counter then continues from 1.
  assign w_slot = bus.zero ? '0 : r_cnt;

  // Slot counter: wraps at SLOTS-1.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       r_cnt <= '0;
    else if (bus.cen) r_cnt <= (w_slot == SW'(SLOTS-1)) ? '0 : w_slot + 1'b1;

  jtopl_pg_mslot_inc u_inc (
    .i_block   (bus.block),
    .i_fnum    (bus.fnum),
    .i_nts     (bus.nts),
    .i_vib_en  (bus.vib_en),
    .i_vib_dep (bus.vib_dep),
    .i_vib_pos (bus.vib_pos),
    .o_phinc   (w_phinc),
    .o_keycode (w_keycode)
  );

  // Stage 1: register increment and slot context.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r1_phinc <= '0; r1_mul <= '0; r1_rst <= 1'b0; r1_slot <= '0; r_keycode <= '0;
    end else if (bus.cen) begin
      r1_phinc <= w_phinc; r1_mul <= bus.mul; r1_rst <= bus.pg_rst;
      r1_slot <= w_slot; r_keycode <= w_keycode;
    end

  // Doubled factor times phinc, then halve: exact for every code including x0.5.
  assign w_prod2 = 22'(r1_phinc) * 22'(MUL_X2[r1_mul]);
  assign w_inc   = PW'(w_prod2 >> 1);

  // Stage 2: register the MUL-scaled increment.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r2_inc <= '0; r2_rst <= 1'b0; r2_slot <= '0;
    end else if (bus.cen) begin
      r2_inc <= w_inc; r2_rst <= r1_rst; r2_slot <= r1_slot;
    end

  // Adjacent slots always differ, so read-modify-write in one cycle is safe.
  assign w_acc = r2_rst ? '0 : r_mem[r2_slot] + r2_inc;

  // Stage 3: phase memory update.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) r_mem[i] <= '0;
    end else if (bus.cen) begin
      r_mem[r2_slot] <= w_acc;
    end

  // Stage 3: outputs taken from the value being written.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_phase_op <= '0; r_slot_out <= '0;
    end else if (bus.cen) begin
      r_phase_op <= w_acc[PW-1 -: OPW]; r_slot_out <= r2_slot;
    end

  assign bus.keycode  = r_keycode;
  assign bus.phase_op = r_phase_op;
  assign bus.slot_out = r_slot_out;
endmodule

// File: tb/tb_jtopl_pg_mslot.sv
// Scoreboard bench for jtopl_pg_mslot: model phases pushed on drive, popped on output.
module tb_jtopl_pg_mslot;
  localparam int SLOTS = 18;
  localparam int PW    = 20;
  localparam int SW    = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jtopl_pg_mslot_if #(.SW(SW)) bus();
  jtopl_pg_mslot #(.SLOTS(SLOTS), .PW(PW), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  typedef struct { int slot; int ph; bit pr; } exp_t;
  exp_t   q[$];
  exp_t   sb_exp;
  bit     sb_have;
  int     n_assert = 0;
  int     n_fail = 0;
  int     m_cnt;
  longint m_ph [SLOTS];
  int     c_blk [SLOTS], c_fn [SLOTS], c_mul [SLOTS], c_vpos [SLOTS];
  bit     c_nts [SLOTS], c_ven [SLOTS], c_vdep [SLOTS];

  function automatic longint exp_inc(int blk, int fn, int mu, bit ven, bit vdep, int vpos);
    int m, off, fmod;
    longint ph, pr;
    m = fn / 128;
    if (!vdep) m = m / 2;
    off = 0;
    if (ven)
      case (vpos)
        1, 3: off = m / 2;
        2:    off = m;
        5, 7: off = -(m / 2);
        6:    off = -m;
        default: off = 0;
      endcase
    fmod = fn + off;
    ph = (longint'(fmod) << blk) / 2;
    case (mu)
      0:      pr = ph / 2;
      11:     pr = ph * 10;
      12, 13: pr = ph * 12;
      14, 15: pr = ph * 15;
      default: pr = ph * mu;
    endcase
    return pr % (longint'(1) << PW);
  endfunction

  task automatic model_clear();
    q.delete();
    m_cnt = 0;
    for (int i = 0; i < SLOTS; i++) m_ph[i] = 0;
  endtask

  task automatic cfg_clear();
    for (int i = 0; i < SLOTS; i++) begin
      c_blk[i] = 0; c_fn[i] = 0; c_mul[i] = 1; c_vpos[i] = 0;
      c_nts[i] = 0; c_ven[i] = 0; c_vdep[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.cen = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_clear();
    rst_n = 1'b1;
  endtask

  // One cen cycle: drive the slot the model expects, push the model result, pop when due.
  task automatic step(input bit z, input int rs);
    int s;
    longint np;
    logic [9:0] fnv;
    logic [3:0] kc;
    @(negedge clk);
    s = z ? 0 : m_cnt;
    bus.cen = 1'b1; bus.zero = z;
    bus.block = 3'(c_blk[s]); bus.fnum = 10'(c_fn[s]); bus.mul = 4'(c_mul[s]);
    bus.nts = c_nts[s]; bus.vib_en = c_ven[s]; bus.vib_dep = c_vdep[s];
    bus.vib_pos = 3'(c_vpos[s]); bus.pg_rst = (s == rs);
    np = (s == rs) ? 0 :
         (m_ph[s] + exp_inc(c_blk[s], c_fn[s], c_mul[s], c_ven[s], c_vdep[s], c_vpos[s]))
         % (longint'(1) << PW);
    m_ph[s] = np;
    q.push_back('{s, int'(np >> 10), s == rs});
    fnv = 10'(c_fn[s]);
    kc = {3'(c_blk[s]), c_nts[s] ? fnv[8] : fnv[9]};
    m_cnt = (s == SLOTS-1) ? 0 : s + 1;
    @(posedge clk); #1;
    n_assert++;
    if (bus.keycode !== kc) begin
      n_fail++;
      $display("FAIL keycode slot=%0d got=%h exp=%h", s, bus.keycode, kc);
    end
    sb_have = 1'b0;
    if (q.size() >= 3) begin
      sb_exp = q.pop_front();
      sb_have = 1'b1;
      n_assert++;
      if (bus.slot_out !== SW'(sb_exp.slot) || bus.phase_op !== 10'(sb_exp.ph)) begin
        n_fail++;
        $display("FAIL scoreboard got slot=%0d ph=%0d exp slot=%0d ph=%0d",
                 bus.slot_out, bus.phase_op, sb_exp.slot, sb_exp.ph);
      end
    end
    bus.cen = 1'b0;
  endtask

  task automatic test_reset();
    bus.cen = 1'b0; bus.zero = 1'b0; bus.block = '0; bus.fnum = '0; bus.mul = '0;
    bus.nts = 1'b0; bus.vib_en = 1'b0; bus.vib_dep = 1'b0; bus.vib_pos = '0; bus.pg_rst = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_assert++;
    if (bus.phase_op !== 10'd0 || bus.slot_out !== '0 || bus.keycode !== 4'd0) begin
      n_fail++;
      $display("FAIL reset ph=%0d slot=%0d kc=%0d exp 0", bus.phase_op, bus.slot_out, bus.keycode);
    end
    model_clear();
    rst_n = 1'b1;
  endtask

  // Slot 0 at fnum 0x200 block 4; phase_op advances by a fixed amount per frame.
  task automatic test_mul(input int mu, input int per_frame);
    int nv = 0;
    do_reset();
    cfg_clear();
    c_fn[0] = 'h200; c_blk[0] = 4; c_mul[0] = mu;
    for (int i = 0; i < SLOTS*6 + 2; i++) begin
      step(1'b0, -1);
      if (sb_have && sb_exp.slot == 0) begin
        nv++;
        n_assert++;
        if (bus.phase_op !== 10'(per_frame * nv) || bus.slot_out !== '0) begin
          n_fail++;
          $display("FAIL mul%0d visit=%0d ph=%0d exp=%0d", mu, nv, bus.phase_op, per_frame*nv);
        end
      end
    end
  endtask

  task automatic test_vibrato();
    int incs [4] = '{0, 903, 889, 899};
    int nv [4] = '{0, 0, 0, 0};
    do_reset();
    cfg_clear();
    for (int k = 1; k < 4; k++) begin
      c_fn[k] = 'h380; c_blk[k] = 1; c_ven[k] = 1'b1; c_vdep[k] = (k != 3);
    end
    c_vpos[1] = 2; c_vpos[2] = 6; c_vpos[3] = 2;
    for (int k = 4; k < SLOTS; k++) begin
      c_fn[k] = $urandom_range(0, 1023); c_blk[k] = $urandom_range(0, 7);
      c_ven[k] = 1'b1; c_vdep[k] = $urandom_range(0, 1); c_vpos[k] = $urandom_range(0, 7);
    end
    for (int i = 0; i < SLOTS*200; i++) begin
      step(1'b0, -1);
      if (sb_have && sb_exp.slot >= 1 && sb_exp.slot <= 3) begin
        nv[sb_exp.slot]++;
        if (nv[sb_exp.slot] % 50 == 0) begin
          n_assert++;
          if (bus.phase_op !== 10'((incs[sb_exp.slot] * nv[sb_exp.slot]) >> 10)) begin
            n_fail++;
            $display("FAIL vib slot=%0d visit=%0d ph=%0d exp=%0d", sb_exp.slot, nv[sb_exp.slot],
                     bus.phase_op, (incs[sb_exp.slot] * nv[sb_exp.slot]) >> 10);
          end
        end
      end
    end
  endtask

  task automatic test_wrap();
    int nv = 0;
    int expv [3] = '{0, 959, 894};
    do_reset();
    cfg_clear();
    c_blk[4] = 7; c_fn[4] = 1023; c_mul[4] = 15;
    for (int i = 0; i < SLOTS*2 + 4; i++) begin
      step(1'b0, -1);
      if (sb_have && sb_exp.slot == 4 && nv < 2) begin
        nv++;
        n_assert++;
        if (bus.phase_op !== 10'(expv[nv])) begin
          n_fail++;
          $display("FAIL wrap visit=%0d ph=%0d exp=%0d", nv, bus.phase_op, expv[nv]);
        end
      end
    end
  endtask

  task automatic test_pg_rst();
    do_reset();
    for (int k = 0; k < SLOTS; k++) begin
      c_fn[k] = $urandom_range(0, 1023); c_blk[k] = $urandom_range(0, 7);
      c_mul[k] = $urandom_range(0, 15); c_nts[k] = $urandom_range(0, 1);
      c_ven[k] = $urandom_range(0, 1); c_vdep[k] = $urandom_range(0, 1);
      c_vpos[k] = $urandom_range(0, 7);
    end
    for (int i = 0; i < SLOTS*8; i++) begin
      step(1'b0, (i >= SLOTS*5 && i < SLOTS*6) ? 3 : -1);
      if (sb_have && sb_exp.pr) begin
        n_assert++;
        if (bus.phase_op !== 10'd0 || bus.slot_out !== SW'(3)) begin
          n_fail++;
          $display("FAIL pg_rst slot=%0d ph=%0d exp slot=3 ph=0", bus.slot_out, bus.phase_op);
        end
      end
    end
  endtask

  task automatic test_zero();
    for (int i = 0; i < SLOTS && m_cnt != 7; i++) step(1'b0, -1);
    step(1'b1, -1);
    step(1'b0, -1);
    step(1'b0, -1);
    n_assert++;
    if (bus.slot_out !== '0) begin
      n_fail++;
      $display("FAIL zero_resync slot=%0d exp=0", bus.slot_out);
    end
    for (int i = 0; i < SLOTS*2; i++) step(1'b0, -1);
  endtask

  task automatic test_cen_hold();
    logic [9:0] ph0;
    logic [SW-1:0] sl0;
    logic [3:0] kc0;
    ph0 = bus.phase_op; sl0 = bus.slot_out; kc0 = bus.keycode;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.cen = 1'b0; bus.zero = $urandom_range(0, 1); bus.pg_rst = $urandom_range(0, 1);
      bus.fnum = 10'($urandom_range(0, 1023)); bus.block = 3'($urandom_range(0, 7));
      bus.mul = 4'($urandom_range(0, 15)); bus.nts = $urandom_range(0, 1);
      @(posedge clk); #1;
      n_assert++;
      if (bus.phase_op !== ph0 || bus.slot_out !== sl0 || bus.keycode !== kc0) begin
        n_fail++;
        $display("FAIL cen_hold cyc=%0d ph=%0d/%0d slot=%0d/%0d kc=%0d/%0d", i,
                 bus.phase_op, ph0, bus.slot_out, sl0, bus.keycode, kc0);
      end
    end
    for (int i = 0; i < SLOTS*2; i++) step(1'b0, -1);
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 5; i++) step(1'b0, -1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_assert++;
    if (bus.phase_op !== 10'd0 || bus.slot_out !== '0 || bus.keycode !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_mid ph=%0d slot=%0d kc=%0d exp 0", bus.phase_op, bus.slot_out, bus.keycode);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < SLOTS*3; i++) step(1'b0, -1);
  endtask

  initial begin
    cfg_clear();
    test_reset();
    test_mul(1, 4);
    test_mul(0, 2);
    test_mul(13, 48);
    test_vibrato();
    test_wrap();
    test_pg_rst();
    test_zero();
    test_cen_hold();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/jtopl_pg_mslot.md
# jtopl_pg_mslot

Multi-slot, pipelined phase generator for the OPL operator chain. It time-multiplexes `SLOTS` operators over one datapath. Per slot it computes the frequency increment from block/fnum with optional vibrato, scales it by the MUL factor, and accumulates it into a per-slot phase memory. Its output is the 10-bit operator phase for the envelope/operator stages downstream. It replaces per-slot combinational phase logic plus external phase storage.

## Interface
Parameters:
- `SLOTS`, 18: operator slots per sample frame, ≥ 2
- `PW`, 20: phase accumulator width, ≥ 17
- `SW`, 5: slot index width, must satisfy 2^SW ≥ SLOTS

Ports:
- `clk` in 1: system clock
- `rst_n` in 1: reset, asynchronous, active-low
- `cen` in 1: clock enable; every state update is gated by it
- `zero` in 1: marks the input slot as slot 0 (resync)
- `block` in 3: octave of the current input slot
- `fnum` in 10: frequency number of the current input slot
- `mul` in 4: multiplier code
- `nts` in 1: keycode note-select
- `vib_en` in 1: vibrato enable for this slot
- `vib_dep` in 1: 1 = deep vibrato, 0 = shallow
- `vib_pos` in 3: LFO vibrato position, global
- `pg_rst` in 1: force this slot's phase to 0 (key-on)
- `keycode` out 4: `{block, nts ? fnum[8] : fnum[9]}`, registered at stage 1
- `phase_op` out 10: `phase[PW-1 -: 10]` of the slot in `slot_out`
- `slot_out` out SW: slot index aligned with `phase_op`

## Operation
- Slot counter `slot_in`:
  - Increments on each `cen` and wraps `SLOTS-1 → 0`.
  - `zero` high on a `cen` cycle loads 0 for that input, overriding the count.
  - The next slot is 1.
- Stage 1, increment:
  - m = `fnum[9:7] >> (vib_dep ? 0 : 1)`.
  - Offset by `vib_pos` 0..7: 0, +(m>>1), +m, +(m>>1), 0, −(m>>1), −m, −(m>>1).
  - Offset is forced to 0 when `vib_en` is 0.
  - fmod = fnum + offset, computed in 11 bits unsigned. No underflow is possible.
  - phinc = (fmod << block) >> 1, 17 bits.
  - Stage 1 registers phinc, mul, pg_rst, slot and keycode.
- Stage 2, multiply:
  - MUL factor by code: 0→½ (phinc>>1), 1→1, 2..10→code, 11→10, 12/13→12, 14/15→15.
  - Product is 21 bits, zero-extended or truncated to PW. Stage 2 registers it.
- Stage 3, accumulate:
  - Reads `mem[slot]` and writes back `pg_rst ? 0 : mem[slot] + inc`, modulo 2^PW.
  - `phase_op` and `slot_out` are registered from the written value.
- `cen` low: all registers, memory and the counter hold.
- Reset clears the phase memory, all pipeline registers, the counter and all outputs to 0.
- `pg_rst` with any fnum: written phase is 0 and `phase_op` = 0 for that slot. The next visit starts from 0 + inc.

## Timing
- Latency is 3 `cen` cycles from slot inputs to `phase_op`/`slot_out`. `keycode` has 1 `cen` cycle latency.
- Throughput is one slot per `cen` cycle; there is no stall or backpressure.
- Each slot's memory is read and written in the same stage-3 cycle. Consecutive slots always differ because SLOTS ≥ 2, so there is no read-after-write hazard.
- A `zero` resync mid-frame:
  - Slots already in the pipeline complete under their old indices.
  - Phases of skipped slots are untouched.
- Reset asserted mid-frame takes effect immediately, asynchronously. After release, the first `cen` processes slot 0 unless `zero` says otherwise, which is again slot 0.

## Structure
- Shared package `jtopl_pkg`:
  - the MUL factor table constant
  - the vibrato sign/shape table for the 8 positions
  - widths 17 (phinc) and 10 (op phase)
- Sub-module `jtopl_pg_mslot_inc`: combinational stage-1 math covering vibrato offset, fmod, shift and keycode. The unit test targets it separately.
- The phase memory is a register array of SLOTS×PW flops inside the top, cleared by reset.

## Test plan
- Reset, then slot 0 with fnum=0x200, block=4, mul=1, vib off, 18 slots per frame → inc 4096. After frame N, slot 0 `phase_op` = 4N and `slot_out` = 0 exactly 3 `cen` after the input.
- Same slot with mul=0 → inc 2048, `phase_op` = 2N. With mul=13 → inc 49152.
- fnum=0x380, block=1, vib_en=1, vib_dep=1, vib_pos=2 → fmod 903, inc 903. vib_pos=6 → 889. vib_dep=0, pos=2 → m=3, fmod 899.
- block=7, fnum=1023, mul=15 → inc 982080. After visit 2, phase = 915584 (wrap), `phase_op` = 894.
- Accumulate 5 frames, then pg_rst on slot 3 → slot 3 `phase_op` = 0. Other slots continue and their values are unaffected.
- `zero` asserted at counter 7 → next `slot_out` sequence restarts at 0 after 3 `cen`. `cen` held low 10 cycles → outputs frozen. `rst_n` pulsed mid-frame → all outputs 0 at once and memory cleared.
